// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Single-port 32-bit data memory behind a valid/ready request
//             channel and a valid/ready response channel. Supports word,
//             signed/unsigned half and signed/unsigned byte loads and stores.
//             One request is in flight at a time. The response appears the
//             cycle after accept and is held until the consumer takes it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W      byte-address width; depth is 2^(ADDR_W-2) 32-bit words
//  Ports
//    clk         system clock, rising-edge active
//    reset       asynchronous active-low reset (memory contents preserved)
//    req_valid   request present
//    req_ready   block can accept a request (IDLE only)
//    MemWrite    1 = store, 0 = load
//    MemOp       000 word, 001 half signed, 010 half unsigned,
//                011 byte signed, 100 byte unsigned, 101-111 illegal
//    addr        byte address
//    wdata       store data, right-aligned
//    resp_valid  response present
//    resp_ready  consumer accepts the response
//    rdata       extended load result; 0 for stores and errors
//    resp_err    request rejected (illegal MemOp or misaligned)
//  Build options
//    DMEM_ALIGN_CHECK_EN  when defined, misaligned word/half accesses are
//                         rejected with resp_err; otherwise the low address
//                         bits below the access size are ignored.
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemWrite,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       rdata,
  output logic              resp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HS   = 3'b001;
  localparam logic [2:0] OP_HU   = 3'b010;
  localparam logic [2:0] OP_BS   = 3'b011;
  localparam logic [2:0] OP_BU   = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic              accept;
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;

  logic              is_word;
  logic              is_half;
  logic              is_byte;
  logic              op_illegal;
  logic              misaligned;
  logic              req_err;

  logic [3:0]        byte_en;
  logic              wr_en;
  logic [31:0]       wr_data;

  logic [31:0]       rd_word;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [31:0]       load_data;
  logic [31:0]       resp_data_next;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign word_idx   = addr[ADDR_W-1:2];
  assign lane       = addr[1:0];

  assign is_word    = (MemOp == OP_WORD);
  assign is_half    = (MemOp == OP_HS) || (MemOp == OP_HU);
  assign is_byte    = (MemOp == OP_BS) || (MemOp == OP_BU);
  assign op_illegal = !(is_word || is_half || is_byte);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (is_word && (lane != 2'b00)) || (is_half && lane[0]);
`else
  // Low address bits below the access size are simply dropped below.
  assign misaligned = 1'b0;
`endif

  assign req_err = op_illegal || misaligned;

  // --------------------------------------------------------------------------
  // Store path: byte enables and lane-replicated write data
  // --------------------------------------------------------------------------
  always_comb begin
    byte_en = 4'b0000;
    wr_data = wdata;
    if (is_word) begin
      byte_en = 4'b1111;
      wr_data = wdata;
    end else if (is_half) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{wdata[15:0]}};
    end else if (is_byte) begin
      byte_en = 4'b0001 << lane;
      wr_data = {4{wdata[7:0]}};
    end
  end

  // Writes commit on the accept edge so a later load observes them.
  assign wr_en = accept && MemWrite && !req_err;

  // --------------------------------------------------------------------------
  // Storage: one byte-wide array per lane (lane n = bits [8n+7:8n]).
  // Not reset: contents survive reset and are undefined at power-up.
  // --------------------------------------------------------------------------
  generate
    for (genvar n = 0; n < 4; n++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && byte_en[n]) begin
          mem[word_idx] <= wr_data[8*n +: 8];
        end
      end

      assign rd_word[8*n +: 8] = mem[word_idx];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Load path: lane select and extension
  // --------------------------------------------------------------------------
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];

  always_comb begin
    load_data = 32'h0000_0000;
    case (MemOp)
      OP_WORD: load_data = rd_word;
      OP_HS:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_HU:   load_data = {16'h0000, half_sel};
      OP_BS:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   load_data = {24'h00_0000, byte_sel};
      default: load_data = 32'h0000_0000;
    endcase
  end

  assign resp_data_next = (MemWrite || req_err) ? 32'h0000_0000 : load_data;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so nothing is accepted (or written) while held.
        req_ready = reset;
        if (req_valid && reset) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Response registers: captured at accept, held through RESP, cleared once
  // the response is consumed so idle outputs read as zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata    <= 32'h0000_0000;
      resp_err <= 1'b0;
    end else if (accept) begin
      rdata    <= resp_data_next;
      resp_err <= req_err;
    end else if ((state == RESP) && resp_ready) begin
      rdata    <= 32'h0000_0000;
      resp_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. A byte-array model of
//             the memory predicts every response; a compare process checks
//             handshake and response outputs on every falling edge. Directed
//             cases pin the model with literal values, followed by random
//             traffic. Honors DMEM_ALIGN_CHECK_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int ADDR_W = 12;
  localparam int NBYTES = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              MemWrite = 1'b0;
  logic [2:0]        MemOp = 3'b000;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       rdata;
  logic              resp_err;

  dmem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemWrite   (MemWrite),
    .MemOp      (MemOp),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .rdata      (rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [7:0]  mb [NBYTES];
  bit          exp_pending = 1'b0;
  logic [31:0] exp_rdata   = '0;
  bit          exp_err     = 1'b0;

  logic [31:0] dut_rdata;
  logic        dut_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_err(input logic [2:0] op, input logic [ADDR_W-1:0] a);
    if (op > 3'd4) return 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if (op == 3'd0 && a[1:0] != 2'b00) return 1'b1;
    if ((op == 3'd1 || op == 3'd2) && a[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [ADDR_W-1:0] a);
    int b;
    logic [15:0] h;
    logic [7:0]  y;
    case (op)
      3'd0: begin
        b = int'({a[ADDR_W-1:2], 2'b00});
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
      3'd1, 3'd2: begin
        b = int'({a[ADDR_W-1:1], 1'b0});
        h = {mb[b+1], mb[b]};
        return (op == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin
        y = mb[int'(a)];
        return (op == 3'd3) ? {{24{y[7]}}, y} : {24'h0, y};
      end
    endcase
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int b;
    case (op)
      3'd0: begin
        b = int'({a[ADDR_W-1:2], 2'b00});
        for (int i = 0; i < 4; i++) mb[b+i] = d[8*i +: 8];
      end
      3'd1, 3'd2: begin
        b = int'({a[ADDR_W-1:1], 1'b0});
        mb[b]   = d[7:0];
        mb[b+1] = d[15:8];
      end
      default: mb[int'(a)] = d[7:0];
    endcase
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_resp_err", {31'b0, resp_err}, 32'd0);
    end else begin
      check("req_ready", {31'b0, req_ready}, {31'b0, !exp_pending});
      check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_pending});
      if (exp_pending) begin
        check("rdata", rdata, exp_rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      end
    end
  end

  // ---------------- driver ----------------
  // Called from a point just after a rising edge with the DUT idle.
  task automatic issue(input bit we, input logic [2:0] op, input logic [ADDR_W-1:0] a,
                       input logic [31:0] wd);
    bit e;
    req_valid = 1'b1;
    MemWrite  = we;
    MemOp     = op;
    addr      = a;
    wdata     = wd;
    @(posedge clk); #1;
    e = model_err(op, a);
    if (we) begin
      if (!e) model_store(op, a, wd);
      exp_rdata = 32'h0;
    end else begin
      exp_rdata = e ? 32'h0 : model_load(op, a);
    end
    exp_err     = e;
    exp_pending = 1'b1;
    req_valid   = 1'b0;
  endtask

  // Stalls the consumer for 'hold' cycles while throwing junk store
  // requests at the busy DUT, then takes the response.
  task automatic finish(input int hold);
    repeat (hold) begin
      req_valid = $urandom_range(0, 1);
      MemWrite  = 1'b1;
      MemOp     = 3'b000;
      addr      = ADDR_W'($urandom);
      wdata     = $urandom;
      @(posedge clk); #1;
    end
    dut_rdata  = rdata;
    dut_err    = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    exp_pending = 1'b0;
    resp_ready  = 1'b0;
    req_valid   = 1'b0;
  endtask

  task automatic xfer(input bit we, input logic [2:0] op, input logic [ADDR_W-1:0] a,
                      input logic [31:0] wd, input int hold);
    issue(we, op, a, wd);
    finish(hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          we;
    logic [2:0]  op;

    #2 reset = 1'b0;
    #1;
    check("por_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("por_rdata", rdata, 32'd0);
    check("por_resp_err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("por_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < NBYTES / 4; i++) xfer(1'b1, 3'd0, ADDR_W'(i * 4), $urandom, 0);

    // Directed cases with literal expectations.
    xfer(1'b1, 3'd0, 12'h010, 32'h8000_00F1, 0);
    check("sw_rdata", dut_rdata, 32'h0);
    xfer(1'b0, 3'd0, 12'h010, 32'h0, 0);
    check("lw_010", dut_rdata, 32'h8000_00F1);
    check("lw_010_err", {31'b0, dut_err}, 32'd0);
    xfer(1'b0, 3'd3, 12'h010, 32'h0, 0);
    check("lb_010", dut_rdata, 32'hFFFF_FFF1);
    xfer(1'b0, 3'd4, 12'h010, 32'h0, 0);
    check("lbu_010", dut_rdata, 32'h0000_00F1);
    xfer(1'b0, 3'd1, 12'h012, 32'h0, 0);
    check("lh_012", dut_rdata, 32'hFFFF_8000);
    xfer(1'b0, 3'd2, 12'h012, 32'h0, 0);
    check("lhu_012", dut_rdata, 32'h0000_8000);
    xfer(1'b1, 3'd3, 12'h013, 32'h1234_56AB, 1);
    xfer(1'b0, 3'd0, 12'h010, 32'h0, 0);
    check("lw_after_sb", dut_rdata, 32'hAB00_00F1);
    xfer(1'b1, 3'd1, 12'h016, 32'hFFFF_C3D2, 0);
    xfer(1'b0, 3'd2, 12'h016, 32'h0, 0);
    check("lhu_016", dut_rdata, 32'h0000_C3D2);

    xfer(1'b0, 3'd0, 12'h011, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("lw_011_err", {31'b0, dut_err}, 32'd1);
    check("lw_011_rdata", dut_rdata, 32'h0);
`else
    check("lw_011_err", {31'b0, dut_err}, 32'd0);
    check("lw_011_rdata", dut_rdata, 32'hAB00_00F1);
`endif
    xfer(1'b0, 3'd7, 12'h010, 32'h0, 0);
    check("op7_err", {31'b0, dut_err}, 32'd1);
    check("op7_rdata", dut_rdata, 32'h0);
    xfer(1'b1, 3'd5, 12'h010, 32'h0, 0);
    check("sw_op5_err", {31'b0, dut_err}, 32'd1);
    xfer(1'b0, 3'd0, 12'h010, 32'h0, 3);
    check("lw_hold3", dut_rdata, 32'hAB00_00F1);

    // Reset while a response is pending.
    issue(1'b0, 3'd0, 12'h010, 32'h0);
    #2;
    reset       = 1'b0;
    exp_pending = 1'b0;
    req_valid   = 1'b0;
    #1;
    check("rst_resp_valid_now", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata_now", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    xfer(1'b0, 3'd0, 12'h010, 32'h0, 0);
    check("lw_after_reset", dut_rdata, 32'hAB00_00F1);

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      we = $urandom_range(0, 1);
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      xfer(we, op, ADDR_W'($urandom), $urandom, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width; memory depth is 2^(ADDR_W-2) words of 32 bits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port MemWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port MemOp  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-008 SHALL have port addr  input  ADDR_W  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-012 SHALL have port rdata  output  32  load result after extension; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request rejected (misaligned or illegal MemOp).

Function
REQ-014 SHALL implement a two-state FSM: IDLE and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid & req_ready.
REQ-016 On accept, SHALL go to RESP with resp_valid=1 on the next cycle (latency 1).
REQ-017 In RESP, SHALL hold resp_valid, rdata and resp_err stable until resp_ready=1, then return to IDLE on that edge; no back-to-back accept in the same cycle.
REQ-018 Store, word: SHALL write all 4 bytes at addr[ADDR_W-1:2].
REQ-019 Store, MemOp 001/010: SHALL write wdata[15:0] to byte lanes {addr[1],0} and {addr[1],1} only.
REQ-020 Store, MemOp 011/100: SHALL write wdata[7:0] to byte lane addr[1:0] only.
REQ-021 Byte lane n SHALL hold bits [8n+7:8n] of the word (little-endian).
REQ-022 Store writes SHALL take effect on the accept edge; a load accepted on a later cycle SHALL return the new data.
REQ-023 Load SHALL select the half or byte from the addressed lane and sign-extend (001, 011) or zero-extend (010, 100) it to 32 bits.
REQ-024 MemOp 101-111 SHALL give resp_err=1 and rdata=0, with no memory write.
REQ-025 Memory contents SHALL be undefined at power-up and SHALL NOT be altered by reset.

Reset
REQ-026 reset low SHALL immediately force state IDLE, resp_valid=0, resp_err=0 and rdata=0; req_ready SHALL be 1 while reset is high and the FSM is in IDLE.
REQ-027 Reset asserted in RESP SHALL drop the pending response; any store already accepted SHALL remain written.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN: when defined, a word access with addr[1:0]!=0 or a half access with addr[0]=1 SHALL give resp_err=1 and rdata=0, with no write.
REQ-029 When DMEM_ALIGN_CHECK_EN is undefined, misaligned low address bits SHALL be ignored: words use addr[1:0]=00, halves use addr[0]=0, and resp_err SHALL be set only by REQ-024.

Verification
REQ-030 Store word 0x8000_00F1 at 0x010, then load MemOp 000 from 0x010 -> resp_valid one cycle after accept, rdata=0x8000_00F1, resp_err=0.
REQ-031 Load 0x010 with MemOp 011 and addr 0x010 -> 0xFFFF_FFF1; with MemOp 100 -> 0x0000_00F1; lh at 0x012 -> 0xFFFF_8000; lhu at 0x012 -> 0x0000_8000.
REQ-032 Store byte 0xAB at 0x013, then load word 0x010 -> 0xAB00_00F1; other lanes unchanged.
REQ-033 Hold resp_ready=0 for 3 cycles in RESP -> resp_valid and rdata stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
REQ-034 Word load at 0x011 -> resp_err=1, rdata=0 with DMEM_ALIGN_CHECK_EN defined; rdata=word at 0x010 with it undefined. MemOp 111 -> resp_err=1 in both builds.
REQ-035 Assert reset in RESP -> resp_valid=0 at once; after release req_ready=1 and the earlier store data reads back intact.
